// File: rtl/ex_pkg.sv
// Shared execute-stage constants, also used by the dispatcher.
package ex_pkg;

    localparam int unsigned RN_W         = 6;
    localparam int unsigned DATA_W       = 64;
    localparam int unsigned NUM_EX_UNITS = 3;

    localparam int unsigned EX_UNIT_ALU = 0;
    localparam int unsigned EX_UNIT_MUL = 1;
    localparam int unsigned EX_UNIT_LSU = 2;

    // Width of a unit index; never zero, even for a single unit.
    function automatic int unsigned unit_idx_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ex_commit_arb_if.sv
// Execute-unit result and register-file writeback signals of the commit arbiter.
interface ex_commit_arb_if #(
    parameter int unsigned NUM_UNITS = ex_pkg::NUM_EX_UNITS,
    parameter int unsigned RN_W      = ex_pkg::RN_W,
    parameter int unsigned DATA_W    = ex_pkg::DATA_W
);
    localparam int unsigned UNIT_W = ex_pkg::unit_idx_w(NUM_UNITS);

    logic [NUM_UNITS-1:0]        unit_valid;
    logic [NUM_UNITS*RN_W-1:0]   unit_rn;
    logic [NUM_UNITS*DATA_W-1:0] unit_data;
    logic [NUM_UNITS-1:0]        unit_stall;
    logic                        wb_ready;
    logic                        wb_valid;
    logic [RN_W-1:0]             wb_rn;
    logic [DATA_W-1:0]           wb_data;
    logic [UNIT_W-1:0]           wb_unit;
    logic                        ovf_err;

    modport master (
        output unit_valid, unit_rn, unit_data, wb_ready,
        input  unit_stall, wb_valid, wb_rn, wb_data, wb_unit, ovf_err
    );

    modport slave (
        input  unit_valid, unit_rn, unit_data, wb_ready,
        output unit_stall, wb_valid, wb_rn, wb_data, wb_unit, ovf_err
    );

endinterface

// File: rtl/ex_commit_fifo2.sv
// Two-entry result queue for one execute unit; a push while full is ignored
// unless a pop frees the head in the same cycle.
module ex_commit_fifo2 #(
    parameter int unsigned ENTRY_W = 70
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] head,
    output logic [1:0]         cnt,
    output logic               full
);

    logic [ENTRY_W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]         cnt_q, cnt_d, level;
    logic               pop_ok, push_ok;

    always_comb begin
        pop_ok  = pop && (cnt_q != 2'd0);
        level   = cnt_q - {1'b0, pop_ok};
        push_ok = push && (level != 2'd2);
        e0_d    = e0_q;
        e1_d    = e1_q;
        if (pop_ok) begin
            e0_d = e1_q;
        end
        // Write into the first free slot after the pop has shifted the queue.
        if (push_ok) begin
            if (level == 2'd0) begin
                e0_d = din;
            end else begin
                e1_d = din;
            end
        end
        cnt_d = level + {1'b0, push_ok};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign head = e0_q;
    assign cnt  = cnt_q;
    assign full = (cnt_q == 2'd2);

endmodule

// File: rtl/ex_commit_arb.sv
// Round-robin arbiter sharing the register-file writeback port among the execute
// units; results that lose arbitration wait in a per-unit 2-entry queue.
module ex_commit_arb #(
    parameter int unsigned NUM_UNITS = ex_pkg::NUM_EX_UNITS,
    parameter int unsigned RN_W      = ex_pkg::RN_W,
    parameter int unsigned DATA_W    = ex_pkg::DATA_W
) (
    input logic            clk,
    input logic            rst_n,
    ex_commit_arb_if.slave bus
);

    localparam int unsigned   UNIT_W    = ex_pkg::unit_idx_w(NUM_UNITS);
    localparam int unsigned   ENTRY_W   = RN_W + DATA_W;
    localparam logic [UNIT_W:0] LAST_UNIT = (UNIT_W + 1)'(NUM_UNITS - 1);

    logic [NUM_UNITS-1:0] push, pop, full, has_q, cand;
    logic [ENTRY_W-1:0]   head [NUM_UNITS];
    logic [ENTRY_W-1:0]   live [NUM_UNITS];
    logic [1:0]           cnt  [NUM_UNITS];

    logic [UNIT_W-1:0]    rr_q, rr_d, win;
    logic                 grant;
    logic [ENTRY_W-1:0]   win_entry;
    logic [NUM_UNITS-1:0] stall_q, stall_d;
    logic                 ovf_q, ovf_hit;
    logic                 wb_valid_q;
    logic [RN_W-1:0]      wb_rn_q;
    logic [DATA_W-1:0]    wb_data_q;
    logic [UNIT_W-1:0]    wb_unit_q;

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
        assign live[g]  = {bus.unit_rn[g*RN_W +: RN_W], bus.unit_data[g*DATA_W +: DATA_W]};
        assign has_q[g] = (cnt[g] != 2'd0);
        assign cand[g]  = has_q[g] | bus.unit_valid[g];

        ex_commit_fifo2 #(
            .ENTRY_W(ENTRY_W)
        ) u_fifo (
            .clk  (clk),
            .rst_n(rst_n),
            .push (push[g]),
            .pop  (pop[g]),
            .din  (live[g]),
            .head (head[g]),
            .cnt  (cnt[g]),
            .full (full[g])
        );
    end

    // Rotate candidates so bit 0 is the unit at rr_q, then take the first set bit.
    logic [2*NUM_UNITS-1:0] cand_rot;
    logic [UNIT_W-1:0]      off;
    logic [UNIT_W:0]        win_sum;

    always_comb begin
        cand_rot = {cand, cand} >> rr_q;
        grant    = 1'b0;
        off      = '0;
        for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            if (bus.wb_ready && !grant && cand_rot[k]) begin
                grant = 1'b1;
                off   = k[UNIT_W-1:0];
            end
        end
        win_sum = {1'b0, rr_q} + {1'b0, off};
        if (win_sum > LAST_UNIT) begin
            win_sum = win_sum - (LAST_UNIT + 1'b1);
        end
        win  = win_sum[UNIT_W-1:0];
        rr_d = rr_q;
        if (grant) begin
            rr_d = ({1'b0, win} == LAST_UNIT) ? '0 : win + 1'b1;
        end
    end

    logic       is_win, take_live;
    logic [1:0] cnt_nxt;

    always_comb begin
        push      = '0;
        pop       = '0;
        stall_d   = '0;
        ovf_hit   = 1'b0;
        win_entry = '0;
        is_win    = 1'b0;
        take_live = 1'b0;
        cnt_nxt   = 2'd0;
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            is_win    = grant && (win == u[UNIT_W-1:0]);
            pop[u]    = is_win && has_q[u];
            // A live winner goes straight to writeback; anything else live is queued.
            take_live = is_win && !has_q[u];
            push[u]   = bus.unit_valid[u] && !take_live && (!full[u] || pop[u]);
            if (bus.unit_valid[u] && full[u] && !pop[u]) begin
                ovf_hit = 1'b1;
            end
            if (is_win) begin
                win_entry = has_q[u] ? head[u] : live[u];
            end
            cnt_nxt    = cnt[u] + {1'b0, push[u]} - {1'b0, pop[u]};
            stall_d[u] = (cnt_nxt != 2'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= '0;
            stall_q    <= '0;
            ovf_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rn_q    <= '0;
            wb_data_q  <= '0;
            wb_unit_q  <= '0;
        end else begin
            rr_q       <= rr_d;
            stall_q    <= stall_d;
            ovf_q      <= ovf_q | ovf_hit;
            wb_valid_q <= grant;
            if (grant) begin
                {wb_rn_q, wb_data_q} <= win_entry;
                wb_unit_q            <= win;
            end
        end
    end

    assign bus.unit_stall = stall_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_rn      = wb_rn_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.wb_unit    = wb_unit_q;
    assign bus.ovf_err    = ovf_q;

endmodule

// File: doc/ex_commit_arb.md
# ex_commit_arb

Shares the single register-file writeback port among the execute units (ALU, multiplier, load/store). Each unit registers a result for exactly one cycle and cannot hold it. This block therefore captures every result the cycle it appears, buffers losers in a per-unit 2-entry queue, and grants the writeback port round-robin. It drives each unit's `stall` input so the dispatcher stops enabling a unit whose results are backing up.

## Interface
- `NUM_UNITS`, default 3: number of execute units; index 0 = ALU, 1 = MUL, 2 = LSU.
- `RN_W`, default 6: destination register-number width.
- `DATA_W`, default 64: result width.

Ports (`i` = unit index; unit `i` occupies bits `[i*W +: W]` of each packed vector):
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `unit_valid`  in  NUM_UNITS  unit `i` presents a result this cycle.
- `unit_rn`  in  NUM_UNITS*RN_W  destination register of each result.
- `unit_data`  in  NUM_UNITS*DATA_W  result value.
- `unit_stall`  out  NUM_UNITS  to unit `i`'s `stall`; dispatcher must not enable unit `i` while high.
- `wb_ready`  in  1  register file accepts a write this cycle.
- `wb_valid`  out  1  registered writeback strobe.
- `wb_rn`  out  RN_W  registered writeback register number.
- `wb_data`  out  DATA_W  registered writeback value.
- `wb_unit`  out  clog2(NUM_UNITS)  index of the unit that produced the current writeback.
- `ovf_err`  out  1  sticky: a result arrived for a full queue.

## Operation
- Per unit: 2-entry FIFO (`cnt` 0..2) plus the live input.
- Candidate for unit `i`:
  - FIFO head if `cnt[i]` != 0;
  - otherwise the live input if `unit_valid[i]`.
- Per-unit ordering is always preserved: when `cnt[i]` != 0, a live result is enqueued behind the head and never bypasses it.
- Arbitration: only when `wb_ready`=1.
  - Search starts at `rr_ptr` and wraps modulo NUM_UNITS; the first unit with a candidate wins.
  - On a grant, `rr_ptr` <= winner+1 (wraps to 0).
  - With no grant, `rr_ptr` holds.
- Winner:
  - If the winner came from its FIFO, the head is popped.
  - If it was the live input, nothing is enqueued.
- Losers, or every unit when `wb_ready`=0: a live valid result is pushed.
  - Push and pop in the same cycle leave `cnt` unchanged.
- Overflow: live valid with `cnt`=2 and no pop that cycle. The result is dropped, `ovf_err` <= 1 and stays set until reset, and queue contents are unchanged.
- `unit_stall[i]` <= (next `cnt[i]` != 0), registered.
  - Rationale: the dispatcher may already have enabled the unit in the cycle the first entry was queued. The second entry absorbs that in-flight result.
- Outputs on a grant: `wb_valid` <= 1 and `wb_rn`/`wb_data`/`wb_unit` <= the winner's values.
- Outputs with no grant: `wb_valid` <= 0 and the other outputs hold their last values.
- Result with `rn`=0 is forwarded unchanged; discarding r0 writes is the register file's job.

## Timing
- Reset (async, immediate): all `cnt`=0, `rr_ptr`=0, `unit_stall`=0, `wb_valid`=0, `wb_rn`=0, `wb_data`=0, `wb_unit`=0, `ovf_err`=0.
  - Any queued or in-flight results are discarded.
  - Release is synchronous to the next rising edge.
- Latency: a live result granted in cycle t gives `wb_valid`=1 in cycle t+1.
  - A queued result waiting k arbitration losses appears k cycles later.
- Throughput: one writeback per cycle while `wb_ready`=1.
- `unit_stall` rises in the cycle after the first enqueue.
  - It falls in the cycle after the pop that empties the queue.
  - In the worst case a unit sees stall for the cycles spent draining 2 entries.
- Round-robin bounds wait: a head candidate is granted within NUM_UNITS `wb_ready` cycles.
- `wb_ready` is sampled combinationally in the grant cycle. Its effect is visible only on next-cycle outputs.

## Structure
- Shared execute package (`ex_pkg`) holds `RN_W`, `DATA_W`, unit index constants (`EX_UNIT_ALU`=0, `EX_UNIT_MUL`=1, `EX_UNIT_LSU`=2) and `NUM_EX_UNITS`. The dispatcher uses the same constants.
- Sub-module `ex_commit_fifo2`: a 2-entry {rn, data} queue.
  - Inputs: `push`, `pop`.
  - Outputs: `head`, `cnt`, `full`.
  - Same clock and reset.
  - Instantiated once per unit via generate.
- Round-robin grant logic stays in the top level.

## Test plan
- Single ALU result, rn=5, data=0x1234, `wb_ready`=1: next cycle `wb_valid`=1, `wb_rn`=5, `wb_data`=0x1234, `wb_unit`=0; `unit_stall`=0 throughout.
- ALU and MUL valid in the same cycle, `rr_ptr`=0: ALU written at t+1 and MUL at t+2; `unit_stall[1]`=1 for exactly one cycle; `rr_ptr` then equals 2.
- `wb_ready`=0 while ALU issues results in 2 consecutive cycles (rn 1, 2), then `wb_ready`=1: writebacks occur in order rn 1 then rn 2; `unit_stall[0]` is high from the 2nd cycle until the cycle after the last pop; `ovf_err`=0.
- Same as above with a 3rd ALU result while `cnt`=2 and `wb_ready`=0: `ovf_err`=1 and stays set; only rn 1 and rn 2 are written back.
- All three units valid every cycle with `wb_ready`=1 (dispatcher obeys stall): grants rotate 0,1,2,0,…; no overflow; each unit is stalled at least once.
- Assert `rst_n`=0 with 2 entries queued and `wb_valid`=1: all outputs go to 0 immediately; after release, no stale writeback appears.
